// File: rtl/m68k_bus_arbiter_pkg.sv
// Shared definitions for the 68000 bus arbiter: state codes, default grant
// timeout and where the arbiter fields sit in the status word.
package m68k_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_OWNED    = 3'd0,
    ARB_DRAIN    = 3'd1,
    ARB_GRANT    = 3'd2,
    ARB_RELEASED = 3'd3,
    ARB_REARM    = 3'd4
  } arb_state_e;

  localparam int ARB_GRANT_TIMEOUT_DEF = 16;

  localparam int STAT_ARB_STATE_LSB = 0;
  localparam int STAT_ARB_STATE_W   = 3;
  localparam int STAT_ARB_ERR_BIT   = 3;

endpackage

// File: rtl/m68k_bus_arbiter_sync_edge.sv
// N-stage synchroniser for an asynchronous level, with one-cycle rise/fall
// pulses and a flag that goes high once the first real sample is through.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o,
  output logic valid_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] valid_q;
  logic              prev_q;

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, which is what makes this a chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {STAGES{RESET_VAL}};
      valid_q <= '0;
      prev_q  <= RESET_VAL;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], d_i};
      valid_q <= {valid_q[STAGES-2:0], 1'b1};
      prev_q  <= sync_q[STAGES-1];
    end
  end

  assign q_o     = sync_q[STAGES-1];
  assign rise_o  = ~prev_q &  sync_q[STAGES-1];
  assign fall_o  =  prev_q & ~sync_q[STAGES-1];
  assign valid_o = valid_q[STAGES-1];

endmodule

// File: rtl/m68k_bus_arbiter.sv
// Hands the 68000 bus between the local cycle engine and external DMA masters
// via BR_n/BG_n/BGACK_n; all decisions are taken on sampled M68K_CLK falls.
module m68k_bus_arbiter
  import m68k_bus_arbiter_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int GRANT_TIMEOUT = ARB_GRANT_TIMEOUT_DEF,
  parameter int CNT_W         = 8
) (
  input  logic       PI_CLK,
  input  logic       RESET_n,
  input  logic       M68K_CLK,
  input  logic       M68K_BR_n,
  input  logic       M68K_BGACK_n,
  input  logic       cyc_req,
  input  logic       cyc_active,
  output logic       cyc_go,
  output logic       M68K_BG_n,
  output logic       bus_oe_n,
  output logic [2:0] arb_state,
  output logic       arb_err
);

  logic m68k_fall, m68k_rise, m68k_s, sync_ok;
  logic br_n_s, br_rise, br_fall, br_valid;
  logic bgack_n_s, bgack_rise, bgack_fall, bgack_valid;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_clk_sync (
    .clk(PI_CLK), .rst_n(RESET_n), .d_i(M68K_CLK),
    .q_o(m68k_s), .rise_o(m68k_rise), .fall_o(m68k_fall), .valid_o(sync_ok)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_br_sync (
    .clk(PI_CLK), .rst_n(RESET_n), .d_i(M68K_BR_n),
    .q_o(br_n_s), .rise_o(br_rise), .fall_o(br_fall), .valid_o(br_valid)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_bgack_sync (
    .clk(PI_CLK), .rst_n(RESET_n), .d_i(M68K_BGACK_n),
    .q_o(bgack_n_s), .rise_o(bgack_rise), .fall_o(bgack_fall), .valid_o(bgack_valid)
  );

  logic unused_sync;
  assign unused_sync = ^{m68k_s, m68k_rise, br_rise, br_fall, br_valid,
                         bgack_rise, bgack_fall, bgack_valid};

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bg_n_q, bg_n_d;
  logic             oe_n_q, oe_n_d;
  logic             err_q, err_d;

  // NOTE: every output of this block is given a default first so no path
  // through the case leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    bg_n_d  = bg_n_q;
    oe_n_d  = oe_n_q;
    cyc_go  = 1'b0;

    unique case (state_q)
      ARB_OWNED: begin
        cyc_go = cyc_req & br_n_s & sync_ok;
        if (m68k_fall && !br_n_s) state_d = cyc_active ? ARB_DRAIN : ARB_GRANT;
      end
      ARB_DRAIN: begin
        if (m68k_fall) begin
          if (!cyc_active)  state_d = ARB_GRANT;
          else if (br_n_s)  state_d = ARB_OWNED;
        end
      end
      ARB_GRANT: begin
        if (m68k_fall) begin
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          if (!bgack_n_s) begin
            state_d = ARB_RELEASED;
          end else if (br_n_s) begin
            state_d = ARB_OWNED;
          end else if (cnt_q <= CNT_W'(1)) begin
            state_d = ARB_OWNED;
            err_d   = 1'b1;
          end
        end
      end
      ARB_RELEASED: begin
        if (m68k_fall && bgack_n_s) state_d = ARB_REARM;
      end
      ARB_REARM: begin
        if (m68k_fall) state_d = br_n_s ? ARB_OWNED : ARB_GRANT;
      end
      default: begin
        if (m68k_fall) state_d = ARB_OWNED;
      end
    endcase

    if (state_d == ARB_GRANT && state_q != ARB_GRANT) cnt_d = CNT_W'(GRANT_TIMEOUT);

    // BG_n stays low across the GRANT->RELEASED fall; it is negated one fall later.
    if (m68k_fall) begin
      bg_n_d = !((state_d == ARB_GRANT) ||
                 (state_q == ARB_GRANT && state_d == ARB_RELEASED));
      oe_n_d = (state_d == ARB_RELEASED) || (state_d == ARB_REARM);
    end
  end

  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= ARB_OWNED;
      cnt_q   <= '0;
      bg_n_q  <= 1'b1;
      oe_n_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bg_n_q  <= bg_n_d;
      oe_n_q  <= oe_n_d;
      err_q   <= err_d;
    end
  end

  assign M68K_BG_n = bg_n_q;
  assign bus_oe_n  = oe_n_q;
  assign arb_state = state_q;
  assign arb_err   = err_q;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Directed bench for m68k_bus_arbiter: each step drives inputs, queues the
// expected outputs and compares them after the following M68K_CLK fall(s).
module tb_m68k_bus_arbiter;

  logic       pi_clk = 1'b0;
  logic       m68k_clk = 1'b1;
  logic       rst_n;
  logic       br_n, bgack_n, cyc_req, cyc_active;
  logic       cyc_go, bg_n, bus_oe_n, arb_err;
  logic [2:0] arb_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic       bg_n;
    logic       oe_n;
    logic [2:0] st;
    logic       err;
    logic       go;
  } exp_t;

  exp_t sb_q[$];

  always #5  pi_clk   = ~pi_clk;
  always #40 m68k_clk = ~m68k_clk;

  m68k_bus_arbiter #(.SYNC_STAGES(2), .GRANT_TIMEOUT(4), .CNT_W(8)) dut (
    .PI_CLK(pi_clk), .RESET_n(rst_n), .M68K_CLK(m68k_clk),
    .M68K_BR_n(br_n), .M68K_BGACK_n(bgack_n),
    .cyc_req(cyc_req), .cyc_active(cyc_active), .cyc_go(cyc_go),
    .M68K_BG_n(bg_n), .bus_oe_n(bus_oe_n), .arb_state(arb_state), .arb_err(arb_err)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb_q.pop_front();
      check_bit({e.tag, ".bg_n"},   bg_n,      e.bg_n);
      check_bit({e.tag, ".oe_n"},   bus_oe_n,  e.oe_n);
      check_st ({e.tag, ".state"},  arb_state, e.st);
      check_bit({e.tag, ".err"},    arb_err,   e.err);
      check_bit({e.tag, ".cyc_go"}, cyc_go,    e.go);
    end
  endtask

  // n>0: wait n M68K_CLK falls plus synchroniser latency; n==0: settle 1 ns.
  task automatic step(input int n, input string tag, input logic e_bg, input logic e_oe,
                      input logic [2:0] e_st, input logic e_err, input logic e_go);
    exp_t e;
    e.tag = tag; e.bg_n = e_bg; e.oe_n = e_oe; e.st = e_st; e.err = e_err; e.go = e_go;
    sb_q.push_back(e);
    if (n > 0) begin
      repeat (n) begin
        @(negedge m68k_clk);
        repeat (5) @(negedge pi_clk);
      end
    end else begin
      #1;
    end
    compare();
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; br_n = 1'b1; bgack_n = 1'b1; cyc_req = 1'b1; cyc_active = 1'b0;
    #12;
    step(0, "reset", 1, 0, 3'd0, 0, 0);
    @(negedge pi_clk);
    rst_n = 1'b1;

    step(1, "idle_owned", 1, 0, 3'd0, 0, 1);

    // Request while idle, BR beats the pending local cycle.
    br_n = 1'b0;
    step(1, "idle_grant", 0, 0, 3'd2, 0, 0);
    br_n = 1'b1;
    step(1, "idle_withdraw", 1, 0, 3'd0, 0, 1);

    // Request during a local cycle drains first.
    cyc_active = 1'b1; br_n = 1'b0;
    step(1, "drain_enter", 1, 0, 3'd1, 0, 0);
    step(3, "drain_hold", 1, 0, 3'd1, 0, 0);
    cyc_active = 1'b0;
    step(1, "drain_grant", 0, 0, 3'd2, 0, 0);
    br_n = 1'b1;
    step(1, "drain_done", 1, 0, 3'd0, 0, 1);

    cyc_active = 1'b1; br_n = 1'b0;
    step(1, "drain2_enter", 1, 0, 3'd1, 0, 0);
    br_n = 1'b1;
    step(1, "drain2_withdraw", 1, 0, 3'd0, 0, 1);
    cyc_active = 1'b0;

    // Full handoff; BGACK wins over BR negation in the same fall.
    br_n = 1'b0;
    step(1, "ho_grant", 0, 0, 3'd2, 0, 0);
    bgack_n = 1'b0; br_n = 1'b1;
    step(1, "ho_released_entry", 0, 1, 3'd3, 0, 0);
    step(1, "ho_released_bg", 1, 1, 3'd3, 0, 0);
    step(8, "ho_released_hold", 1, 1, 3'd3, 0, 0);
    bgack_n = 1'b1;
    step(1, "ho_rearm", 1, 1, 3'd4, 0, 0);
    cyc_req = 1'b0;
    step(1, "ho_owned", 1, 0, 3'd0, 0, 0);
    cyc_req = 1'b1;
    step(0, "ho_go_follows_req", 1, 0, 3'd0, 0, 1);

    // REARM with BR still low re-grants directly.
    br_n = 1'b0;
    step(1, "rg_grant", 0, 0, 3'd2, 0, 0);
    bgack_n = 1'b0;
    step(1, "rg_released", 0, 1, 3'd3, 0, 0);
    bgack_n = 1'b1;
    step(1, "rg_rearm", 1, 1, 3'd4, 0, 0);
    step(1, "rg_regrant", 0, 0, 3'd2, 0, 0);
    br_n = 1'b1;
    step(1, "rg_owned", 1, 0, 3'd0, 0, 1);

    // BR pulsed for three periods, no BGACK: no timeout.
    br_n = 1'b0;
    step(1, "pulse_grant", 0, 0, 3'd2, 0, 0);
    step(2, "pulse_hold", 0, 0, 3'd2, 0, 0);
    br_n = 1'b1;
    step(1, "pulse_release", 1, 0, 3'd0, 0, 1);

    // Timeout: BG_n negated on the 4th fall after assertion.
    br_n = 1'b0;
    step(1, "to_grant", 0, 0, 3'd2, 0, 0);
    step(3, "to_wait3", 0, 0, 3'd2, 0, 0);
    step(1, "to_expire", 1, 0, 3'd0, 1, 0);
    br_n = 1'b1;
    step(2, "to_sticky", 1, 0, 3'd0, 1, 1);

    // Asynchronous reset mid-grant.
    br_n = 1'b0;
    step(1, "rst_grant", 0, 0, 3'd2, 1, 0);
    rst_n = 1'b0;
    step(0, "rst_async", 1, 0, 3'd0, 0, 0);
    @(negedge pi_clk);
    br_n = 1'b1;
    rst_n = 1'b1;
    step(1, "rst_recover", 1, 0, 3'd0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m68k_bus_arbiter.md
Name: m68k_bus_arbiter

Overview:
- Sequences ownership of the 68000 bus between the local Pi-driven cycle engine and external DMA masters using BR_n/BG_n/BGACK_n.
- Runs in the fast Pi clock domain and treats M68K_CLK as a sampled data signal.
- Gates new local cycles and controls the bus-driver output enables.
- Drives M68K_BG_n, which the bus interface currently ties inactive.

Parameters:
SYNC_STAGES, 2, synchroniser depth for every asynchronous input (M68K_CLK, BR_n, BGACK_n); minimum 2.
GRANT_TIMEOUT, 16, M68K_CLK falling edges to wait for BGACK_n after asserting BG_n before the grant is withdrawn; range 2..255.
CNT_W, 8, width of the timeout counter; must hold GRANT_TIMEOUT.

Ports:
PI_CLK  in  1  sole clock (~200 MHz Pi clock); all logic rises on it.
RESET_n  in  1  asynchronous active-low reset.
M68K_CLK  in  1  7 MHz bus clock, sampled through synchroniser, never used as a clock.
M68K_BR_n  in  1  external bus request, active low.
M68K_BGACK_n  in  1  external bus-grant acknowledge, active low.
cyc_req  in  1  level: Pi side has a bus cycle pending (op_req).
cyc_active  in  1  level: cycle engine is between S1 and S7 inclusive.
cyc_go  out  1  level: local engine may leave S0/Sr on its next M68K_CLK falling edge.
M68K_BG_n  out  1  bus grant, active low.
bus_oe_n  out  1  active-low enable for AS/UDS/LDS/RW/FC and address/data latch drivers.
arb_state  out  3  current state code, for the status register.
arb_err  out  1  sticky: grant timed out without BGACK; cleared only by reset.

Behaviour:
- Synchronise all three asynchronous inputs with SYNC_STAGES flops.
- fall = falling edge detected on the synchronised M68K_CLK (previous stage 1, current stage 0); pulses one PI_CLK cycle.
- All state transitions occur only on PI_CLK cycles where fall=1. The exception is reset, which acts immediately.
- States (arb_state encoding in brackets):
  - OWNED [0]: local master owns the bus. BG_n=1, bus_oe_n=0, cyc_go = cyc_req & BR_n_s.
    - BR_n_s=0 and cyc_active=0 -> GRANT.
    - BR_n_s=0 and cyc_active=1 -> DRAIN.
  - DRAIN [1]: cyc_go=0, BG_n=1, bus_oe_n=0.
    - cyc_active=0 -> GRANT.
    - BR_n_s=1 -> OWNED (request withdrawn).
  - GRANT [2]: BG_n=0, bus_oe_n=0, cyc_go=0. On entry, load the counter with GRANT_TIMEOUT. The counter decrements per fall.
    - BGACK_n_s=0 -> RELEASED.
    - else BR_n_s=1 -> OWNED.
    - else counter reaches 0 -> OWNED and set arb_err.
  - RELEASED [3]: BG_n=1 on the first fall in this state, bus_oe_n=1, cyc_go=0.
    - BGACK_n_s=1 -> REARM.
  - REARM [4]: bus_oe_n=1, cyc_go=0; provides one full M68K_CLK period of bus turnaround.
    - next fall -> OWNED, unless BR_n_s=0, in which case -> GRANT (re-grant without a local cycle).
  - Codes 5-7 are unreachable; they decode to OWNED.
- Simultaneous events at a fall:
  - BR_n_s=0 and cyc_req=1 in OWNED with cyc_active=0: BR wins. cyc_go is deasserted combinationally with the state change and the local cycle waits.
  - BGACK_n_s=0 and BR_n_s=1 in GRANT: BGACK wins.
- cyc_go is combinational from state and the synchronised inputs. It is never high while bus_oe_n=1.
- bus_oe_n and BG_n are registered. bus_oe_n goes high in the same PI_CLK cycle that RELEASED is entered.
- Reset values: state OWNED, BG_n=1, bus_oe_n=0, cyc_go=0 until the first synchronised sample, arb_err=0, counter 0, synchronisers set to the inactive level (1).
- Reset asserted mid-grant: BG_n returns to 1 asynchronously.

Decomposition:
- Shared package holds:
  - arb state localparams ARB_OWNED..ARB_REARM (3-bit);
  - GRANT_TIMEOUT default;
  - status bit positions for arb_state/arb_err in the status word.
- One sub-module, sync_edge: an N-stage synchroniser with rise/fall pulse outputs. It is reused for M68K_CLK, BR_n and BGACK_n, and later by the cycle engine.

Test Plan:
- BR_n low while idle, cyc_active=0 -> BG_n low within 2 M68K_CLK falls; arb_state=2; cyc_go=0.
- BR_n low during a local cycle (cyc_active=1 for 4 M68K_CLK periods) -> BG_n stays 1, arb_state=1 until cyc_active drops; then BG_n=0 on the next fall.
- Full handoff: BG_n=0, BGACK_n low, BR_n high, 10 periods, BGACK_n high -> bus_oe_n=1 during RELEASED. BG_n=1 after the first fall. One REARM period, then OWNED with cyc_go=cyc_req.
- BR_n pulsed low for 3 periods with no BGACK -> BG_n asserted, then negated at the fall after BR_n_s returns high; arb_err=0.
- BR_n held low, BGACK_n never asserted, GRANT_TIMEOUT=4 -> BG_n negated after exactly 4 falls; arb_err=1 and stays 1.
- RESET_n pulsed low while in GRANT -> BG_n=1 immediately (no PI_CLK edge needed); state 0; arb_err=0.
